// File: rtl/udt_listen_hs_engine.sv
// rtl/udt_listen_hs_engine.sv - UDT server-side listen/cookie handshake engine
// Parses 64-byte handshake packets from a DATA_W stream and issues cookie/accept response requests.
module udt_listen_hs_engine #(
    parameter int DATA_W      = 64,
    parameter int UDT_VERSION = 4,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   handshake_tdata,
    input  logic [DATA_W/8-1:0] handshake_tkeep,
    input  logic                handshake_tvalid,
    input  logic                handshake_tlast,
    output logic                handshake_tready,
    input  logic                Req_Connect,
    output logic                Res_Connect,
    input  logic                Req_Close,
    output logic                Res_Close,
    input  logic [31:0]         MSSize,
    input  logic [31:0]         FlightFlagSize,
    input  logic [31:0]         INIT_SEQ,
    input  logic [31:0]         local_cookie,
    output logic                req_tvalid,
    input  logic                req_tready,
    output logic [1:0]          req_kind,
    output logic [31:0]         req_mss,
    output logic [31:0]         req_flight,
    output logic [31:0]         req_peer_isn,
    output logic [31:0]         req_peer_sock,
    output logic [31:0]         req_local_isn,
    output logic                connected,
    output logic [15:0]         err_cnt
);

    localparam int          NB        = 512 / DATA_W;
    localparam logic [4:0]  LAST_BEAT = 5'(NB - 1);
    localparam bit          TO_EN     = (TIMEOUT_CYC != 0);
    localparam logic [31:0] TO_LAST   = TO_EN ? 32'(TIMEOUT_CYC - 1) : 32'd0;
    localparam logic [31:0] VERSION   = 32'(UDT_VERSION);

    typedef enum logic [1:0] {CLOSED, LISTEN, WAIT_SECOND, CONNECTED} state_t;

    state_t              state, state_next;
    logic [511-DATA_W:0] pkt_sr;
    logic [511:0]        full_pkt;
    logic [4:0]          beat_cnt;
    logic                overrun, keep_bad, discard;
    logic [31:0]         timer;
    logic                connect_q, close_q;
    logic                issue_cookie, issue_accept, err_inc, timed_out;

    logic beat, pkt_end, live, req_fire, connect_rise, close_rise;
    logic pkt_legal, is_syn1, is_syn2, cookie_ok;
    logic [31:0] w0, w4, w6, w7, w8, w9, w10, w11;
    logic unused_fields;

    assign handshake_tready = ~req_tvalid;
    assign beat         = handshake_tvalid & handshake_tready;
    assign pkt_end      = beat & handshake_tlast;
    assign live         = pkt_end & ~discard & ~Req_Close;
    assign req_fire     = req_tvalid & req_tready;
    assign connect_rise = Req_Connect & ~connect_q;
    assign close_rise   = Req_Close & ~close_q;
    assign connected    = (state == CONNECTED);

    // The final beat is combined with the stored beats so the decision lands on the tlast edge.
    assign full_pkt = {pkt_sr, handshake_tdata};
    assign w0  = full_pkt[511 -: 32];
    assign w4  = full_pkt[511 - 4*32 -: 32];
    assign w6  = full_pkt[511 - 6*32 -: 32];
    assign w7  = full_pkt[511 - 7*32 -: 32];
    assign w8  = full_pkt[511 - 8*32 -: 32];
    assign w9  = full_pkt[511 - 9*32 -: 32];
    assign w10 = full_pkt[511 - 10*32 -: 32];
    assign w11 = full_pkt[511 - 11*32 -: 32];
    // Header words the engine does not interpret.
    assign unused_fields = ^{full_pkt[495:384], full_pkt[351:320], full_pkt[127:0]};

    assign pkt_legal = (beat_cnt == LAST_BEAT) && !overrun && !keep_bad && (&handshake_tkeep)
                       && w0[31] && (w0[30:16] == 15'd0) && (w4 == VERSION);
    assign is_syn1   = (w9 == 32'd1);
    assign is_syn2   = (w9 == 32'hFFFF_FFFF);
    assign cookie_ok = (w11 == local_cookie);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CLOSED;
        else        state <= state_next;
    end

    always_comb begin
        state_next   = state;
        issue_cookie = 1'b0;
        issue_accept = 1'b0;
        err_inc      = 1'b0;
        timed_out    = 1'b0;
        case (state)
            CLOSED: begin
                if (connect_rise) state_next = LISTEN;
            end
            LISTEN: begin
                if (live) begin
                    if (!pkt_legal)   err_inc      = 1'b1;
                    else if (is_syn1) issue_cookie = 1'b1;
                end
            end
            WAIT_SECOND: begin
                // A pending response holds off the fallback so an issued accept is never lost.
                if (TO_EN && !req_tvalid && timer >= TO_LAST) begin
                    timed_out  = 1'b1;
                    state_next = LISTEN;
                end else if (live) begin
                    if (!pkt_legal)     err_inc      = 1'b1;
                    else if (is_syn1)   issue_cookie = 1'b1;
                    else if (is_syn2) begin
                        if (cookie_ok)  issue_accept = 1'b1;
                        else            err_inc      = 1'b1;
                    end
                end
            end
            CONNECTED: begin
                if (live) begin
                    if (!pkt_legal)                err_inc      = 1'b1;
                    else if (is_syn2 && cookie_ok) issue_accept = 1'b1;
                end
            end
            default: state_next = CLOSED;
        endcase
        if (req_fire) state_next = (req_kind == 2'd2) ? CONNECTED : WAIT_SECOND;
        if (Req_Close) begin
            state_next   = CLOSED;
            issue_cookie = 1'b0;
            issue_accept = 1'b0;
            err_inc      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_sr        <= '0;
            beat_cnt      <= 5'd0;
            overrun       <= 1'b0;
            keep_bad      <= 1'b0;
            discard       <= 1'b0;
            timer         <= 32'd0;
            connect_q     <= 1'b0;
            close_q       <= 1'b0;
            Res_Connect   <= 1'b0;
            Res_Close     <= 1'b0;
            req_tvalid    <= 1'b0;
            req_kind      <= 2'd0;
            req_mss       <= 32'd0;
            req_flight    <= 32'd0;
            req_peer_isn  <= 32'd0;
            req_peer_sock <= 32'd0;
            req_local_isn <= 32'd0;
            err_cnt       <= 16'd0;
        end else begin
            connect_q   <= Req_Connect;
            close_q     <= Req_Close;
            Res_Connect <= (state == CLOSED) && connect_rise && !Req_Close;
            Res_Close   <= close_rise;

            if (beat) begin
                pkt_sr <= full_pkt[511-DATA_W:0];
                if (handshake_tlast) begin
                    beat_cnt <= 5'd0;
                    overrun  <= 1'b0;
                    keep_bad <= 1'b0;
                end else begin
                    keep_bad <= keep_bad | ~(&handshake_tkeep);
                    if (beat_cnt == LAST_BEAT) overrun  <= 1'b1;
                    else                       beat_cnt <= beat_cnt + 5'd1;
                end
            end

            // A close mid-packet discards the rest of that packet even if listening reopens.
            if (Req_Close && !pkt_end && (beat || beat_cnt != 5'd0 || overrun)) discard <= 1'b1;
            else if (pkt_end)                                                 discard <= 1'b0;

            if (state != WAIT_SECOND || state_next != WAIT_SECOND || req_fire) timer <= 32'd0;
            else if (timer < TO_LAST)                                          timer <= timer + 32'd1;

            if (Req_Close || req_fire) begin
                req_tvalid <= 1'b0;
            end else if (issue_cookie || issue_accept) begin
                req_tvalid    <= 1'b1;
                req_kind      <= issue_accept ? 2'd2 : 2'd1;
                req_mss       <= (MSSize < w7) ? MSSize : w7;
                req_flight    <= (FlightFlagSize < w8) ? FlightFlagSize : w8;
                req_peer_isn  <= w6;
                req_peer_sock <= w10;
                req_local_isn <= INIT_SEQ;
            end

            if (err_inc && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule
